// File: rtl/keypad_entry.sv
// Keypad entry buffer: turns scanner key events into a BCD number with
// clear/backspace/enter editing and hands the committed value downstream via valid/ready.
module keypad_entry #(
    parameter int unsigned DIGITS    = 4,
    parameter logic [5:0]  KEY_CLEAR = 6'h0A,
    parameter logic [5:0]  KEY_ENTER = 6'h0B,
    parameter logic [5:0]  KEY_BKSP  = 6'h0C
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [5:0]            key_code,
    input  logic                  key_ena,
    input  logic                  entry_ready,
    output logic [4*DIGITS-1:0]   disp_bcd,
    output logic [3:0]            digit_cnt,
    output logic [4*DIGITS-1:0]   entry_value,
    output logic                  entry_valid,
    output logic                  key_err
);

    localparam int unsigned W       = 4 * DIGITS;
    localparam logic [3:0]  MAX_CNT = 4'(DIGITS);

    // Handshake: entry_value is offered while entry_valid=1 and is consumed on the
    // rising edge where entry_ready=1; entry_value never changes while entry_valid=1.
    typedef enum logic {
        ENTRY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    state_t         state, state_nxt;
    logic           ena_q;
    logic [W-1:0]   buf_q, buf_nxt;
    logic [3:0]     cnt_q, cnt_nxt;
    logic [W-1:0]   value_q, value_nxt;
    logic           valid_q, valid_nxt;
    logic           err_q, err_nxt;

    logic           key_event;
    logic           is_digit;

    // One event per press: rising edge of the level-style Data_ena.
    assign key_event = key_ena & ~ena_q;
    assign is_digit  = (key_code <= 6'h09);

    always_comb begin
        state_nxt = state;
        buf_nxt   = buf_q;
        cnt_nxt   = cnt_q;
        value_nxt = value_q;
        valid_nxt = valid_q;
        err_nxt   = 1'b0;

        unique case (state)
            ENTRY: begin
                if (key_event) begin
                    if (is_digit) begin
                        if (cnt_q < MAX_CNT) begin
                            buf_nxt = (buf_q << 4) | W'(key_code[3:0]);
                            cnt_nxt = cnt_q + 4'd1;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end else if (key_code == KEY_CLEAR) begin
                        buf_nxt = '0;
                        cnt_nxt = 4'd0;
                    end else if (key_code == KEY_BKSP) begin
                        if (cnt_q != 4'd0) begin
                            buf_nxt = buf_q >> 4;
                            cnt_nxt = cnt_q - 4'd1;
                        end
                    end else if (key_code == KEY_ENTER) begin
                        if (cnt_q != 4'd0) begin
                            value_nxt = buf_q;
                            valid_nxt = 1'b1;
                            state_nxt = HOLD;
                        end else begin
                            err_nxt = 1'b1;
                        end
                    end
                end
            end
            HOLD: begin
                // Keys are never queued while waiting for the consumer.
                if (key_event) begin
                    err_nxt = 1'b1;
                end
                if (entry_ready) begin
                    valid_nxt = 1'b0;
                    buf_nxt   = '0;
                    cnt_nxt   = 4'd0;
                    state_nxt = ENTRY;
                end
            end
            default: begin
                state_nxt = ENTRY;
            end
        endcase
    end

    // ena_q resets high so a key held through reset release is not an event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ENTRY;
            ena_q   <= 1'b1;
            buf_q   <= '0;
            cnt_q   <= 4'd0;
            value_q <= '0;
            valid_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            ena_q   <= key_ena;
            buf_q   <= buf_nxt;
            cnt_q   <= cnt_nxt;
            value_q <= value_nxt;
            valid_q <= valid_nxt;
            err_q   <= err_nxt;
        end
    end

    assign disp_bcd    = buf_q;
    assign digit_cnt   = cnt_q;
    assign entry_value = value_q;
    assign entry_valid = valid_q;
    assign key_err     = err_q;

endmodule

// File: doc/keypad_entry.md
Name: keypad_entry

Overview:
- Sits directly downstream of the keypad scanner and consumes its 6-bit key code (Dout) and Data_ena strobe.
- Assembles key presses into a DIGITS-long BCD entry buffer, with clear, backspace and enter keys.
- On enter, presents the completed number to the next stage through a valid/ready handshake.
- Also drives the live buffer for display.

Parameters:
- DIGITS, 4, number of BCD digits in the entry buffer (1..8).
- KEY_CLEAR, 6'h0A, key code that clears the buffer.
- KEY_ENTER, 6'h0B, key code that commits the buffer.
- KEY_BKSP, 6'h0C, key code that deletes the last digit.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- key_code  input  6  key code from the scanner's Dout; digits are 6'h00..6'h09.
- key_ena  input  1  scanner Data_ena; level, may stay high for many cycles per press.
- entry_ready  input  1  downstream accepts entry_value when high with entry_valid.
- disp_bcd  output  4*DIGITS  live buffer; newest digit in bits [3:0].
- digit_cnt  output  4  number of digits currently in the buffer (0..DIGITS).
- entry_value  output  4*DIGITS  committed number, stable while entry_valid=1.
- entry_valid  output  1  committed number available.
- key_err  output  1  one-cycle pulse on a rejected key event.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - disp_bcd=0, digit_cnt=0, entry_value=0, entry_valid=0, key_err=0, state=ENTRY.
  - Edge register ena_q=1, so a key held through reset release is not counted until released and pressed again.
- Key event:
  - Defined as key_ena=1 sampled with ena_q=0; ena_q<=key_ena every cycle.
  - key_code is sampled at the event edge.
  - Results are visible after that same edge (1-cycle latency from first high sample).
  - A level held high produces exactly one event.
- State ENTRY:
  - Digit (0x00..0x09), digit_cnt<DIGITS: disp_bcd<={disp_bcd<<4, code[3:0]} truncated to 4*DIGITS, digit_cnt+1.
  - Digit, digit_cnt==DIGITS: buffer unchanged, key_err pulse.
  - KEY_CLEAR: disp_bcd=0, digit_cnt=0, no error.
  - KEY_BKSP, digit_cnt>0: disp_bcd>>=4, digit_cnt-1.
  - KEY_BKSP, digit_cnt==0: no-op, no error.
  - KEY_ENTER, digit_cnt>0: entry_value<=disp_bcd, entry_valid<=1, go to HOLD; disp_bcd/digit_cnt keep their value for display.
  - KEY_ENTER, digit_cnt==0: key_err pulse, stay in ENTRY.
  - Any other code (0x0D..0x3F, excluding parameter codes): ignored, no error.
- State HOLD:
  - entry_valid=1 and entry_value frozen until entry_ready is sampled high.
  - At that edge: entry_valid<=0, disp_bcd<=0, digit_cnt<=0, go to ENTRY.
  - Every key event in HOLD is discarded and pulses key_err, including one coincident with entry_ready.
  - A discarded key is not replayed after returning to ENTRY.
- entry_ready is ignored in ENTRY.
- key_err is high for exactly one cycle per rejected event and never asserts without an event.
- Reset mid-entry or in HOLD: immediate return to the reset values above; a pending entry_value is lost.
- Parameter code collisions with digit codes are illegal; behaviour is undefined.

Test Plan:
- Reset, then key_ena pulses with codes 1,2,3 (one event each, low gap between) -> disp_bcd=16'h0123, digit_cnt=3, entry_valid=0.
- Key_ena held high 10 cycles with code 5 -> exactly one digit appended; disp_bcd=16'h0005.
- Enter 9,8,7,6, then a fifth digit 4 -> key_err one pulse, disp_bcd stays 16'h9876, digit_cnt=4; then BKSP -> 16'h0987, cnt=3.
- Digits 4,2, ENTER with entry_ready=0 -> entry_valid=1, entry_value=16'h0042 held; a digit event in HOLD pulses key_err with entry_value unchanged; entry_ready=1 for one cycle -> entry_valid=0, disp_bcd=0, cnt=0.
- ENTER with empty buffer -> key_err pulse, entry_valid stays 0; CLEAR after digits 7,7 -> disp_bcd=0, cnt=0, no key_err.
- rst_n asserted mid-cycle while in HOLD with key_ena held high -> outputs zero immediately; after release no event until key_ena drops and rises again.
